bcd_updown_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_updown_counter_if.sv | 22 ++
 rtl/bcd_digit_cell.sv | 29 ++
 rtl/bcd_updown_counter.sv | 82 ++++++++
 tb/tb_bcd_updown_counter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and per-digit helpers for the decade counter.
// Optional build macro used by the counter top: BCD_CNT_ONEHOT_EN.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic bcd_is_valid(bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

  // One decade step with wrap; callers guarantee d is already a legal digit.
  function automatic bcd_digit_t bcd_step(bcd_digit_t d, logic up);
    if (up)
      return (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
    else
      return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle of the BCD up/down counter; master drives, slave is the counter.
interface bcd_updown_counter_if #(
  parameter int unsigned DIGITS = 1
) ();
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   bcd;
  logic                  tc;
  logic                  load_err;

  modport master (
    output en, up, load, din,
    input  bcd, tc, load_err
  );

  modport slave (
    input  en, up, load, din,
    output bcd, tc, load_err
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One decade of the counter: loadable BCD digit that steps up or down with wrap.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  bcd_digit_t d,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  // Illegal load nibbles collapse to 0 so q never leaves 0..9.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= BCD_MIN;
    else if (load)
      q <= bcd_is_valid(d) ? d : BCD_MIN;
    else if (step)
      q <= bcd_step(q, up);
  end

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable multi-digit up/down BCD counter with parallel load (CD4029 decade style).
// Define BCD_CNT_ONEHOT_EN to add the registered 1-of-10 image of digit 0 on dec0.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_updown_counter_if.slave   bus
`ifdef BCD_CNT_ONEHOT_EN
  ,
  output logic [9:0]            dec0
`endif
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] bad;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   chain_max;
  logic [DIGITS:0]   chain_min;

  // chain_*[k]: all digits below k sit at the wrap boundary for the current direction.
  always_comb begin
    chain_max    = '0;
    chain_min    = '0;
    chain_max[0] = 1'b1;
    chain_min[0] = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      chain_max[k+1] = chain_max[k] & at_max[k];
      chain_min[k+1] = chain_min[k] & at_min[k];
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign step[k] = bus.en & (bus.up ? chain_max[k] : chain_min[k]);
    assign bad[k]  = !bcd_is_valid(bus.din[4*k +: 4]);

    bcd_digit_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (bus.load),
      .d      (bus.din[4*k +: 4]),
      .step   (step[k]),
      .up     (bus.up),
      .q      (bus.bcd[4*k +: 4]),
      .at_max (at_max[k]),
      .at_min (at_min[k])
    );
  end

  assign bus.tc = bus.en & ~bus.load & (bus.up ? chain_max[DIGITS] : chain_min[DIGITS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.load_err <= 1'b0;
    else
      bus.load_err <= bus.load & (|bad);
  end

`ifdef BCD_CNT_ONEHOT_EN
  bcd_digit_t d0_next;

  // Mirrors digit 0's next value so dec0 updates on the same edge as bcd.
  always_comb begin
    d0_next = bus.bcd[3:0];
    if (bus.load)
      d0_next = bcd_is_valid(bus.din[3:0]) ? bus.din[3:0] : BCD_MIN;
    else if (step[0])
      d0_next = bcd_step(bus.bcd[3:0], bus.up);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dec0 <= 10'b0000000001;
    else
      dec0 <= 10'(1) << d0_next;
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: decimal-arithmetic model, directed + random stimulus.
module tb_bcd_updown_counter;
  import bcd_pkg::*;

  localparam int D = 2;
  localparam int W = 4 * D;
  localparam int M = 100;

  typedef struct {
    logic         tc;
    logic [W-1:0] bcd;
    logic         err;
    int           d0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model   = 0;

  bcd_updown_counter_if #(.DIGITS(D)) bus ();

`ifdef BCD_CNT_ONEHOT_EN
  logic [9:0] dec0;
  bcd_updown_counter #(.DIGITS(D)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus), .dec0(dec0));
`else
  bcd_updown_counter #(.DIGITS(D)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Model: counter value is a plain integer modulo 10^D.
  task automatic cyc(input logic e, input logic u, input logic l, input logic [W-1:0] d);
    exp_t x;
    int   lv = 0;
    int   sc = 1;
    logic er = 1'b0;
    @(negedge clk);
    bus.en = e; bus.up = u; bus.load = l; bus.din = d;
    for (int k = 0; k < D; k++) begin
      int nib = int'(d[4*k +: 4]);
      if (nib > 9) begin
        er  = 1'b1;
        nib = 0;
      end
      lv += nib * sc;
      sc *= 10;
    end
    x.tc = e && !l && (u ? (model == M - 1) : (model == 0));
    if (l)
      model = lv;
    else if (e)
      model = u ? (model + 1) % M : (model + M - 1) % M;
    x.bcd = to_bcd(model);
    x.err = l && er;
    x.d0  = model % 10;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.din = '0;
    rst_n = 1'b0;
    #1;
    chk("reset_bcd", 32'(bus.bcd), 32'(0));
    chk("reset_load_err", 32'(bus.load_err), 32'(0));
    chk("reset_tc", 32'(bus.tc), 32'(0));
`ifdef BCD_CNT_ONEHOT_EN
    chk("reset_dec0", 32'(dec0), 32'(1));
`endif
    model = 0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: tc is checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        chk("tc", 32'(bus.tc), 32'(sb[0].tc));
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("bcd", 32'(bus.bcd), 32'(x.bcd));
        chk("load_err", 32'(bus.load_err), 32'(x.err));
`ifdef BCD_CNT_ONEHOT_EN
        chk("dec0", 32'(dec0), 32'(1) << x.d0);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.din = '0;
    do_reset();

    cyc(1'b0, 1'b1, 1'b1, 8'h46);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    do_reset();

    cyc(1'b0, 1'b1, 1'b1, 8'h98);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);

    cyc(1'b0, 1'b0, 1'b1, 8'h10);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);

    cyc(1'b1, 1'b1, 1'b1, 8'h3C);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'hF7);

    cyc(1'b0, 1'b1, 1'b1, 8'h55);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);

    // Walk a full decade of digit 0 and across the digit-1 carry.
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic l = ($urandom_range(0, 9) == 0);
      logic e = ($urandom_range(0, 4) != 0);
      logic u = $urandom_range(0, 1) == 1;
      logic [W-1:0] d = W'($urandom);
      cyc(e, u, l, d);
    end

    cyc(1'b0, 1'b0, 1'b1, 8'h47);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    do_reset();

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
